lcd_cmd_sched: RTL

- Command scheduler in front of the LCD SPI controller, i.e. the block taking command codes 1..5 over valid/busy/error.
- After reset it runs an automatic boot sequence: INITIAL, then an optional clear colour.
- It then shares the controller between a host command queue and the image pipeline's frame request, using round-robin arbitration.
- It retries failed commands and reports persistent faults.

---
 rtl/lcd_cmd_sched.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sched.sv
// Front-end scheduler for the LCD SPI controller: boot sequence, host queue vs image request
// round-robin, retry on error or missing acknowledge, sticky fault report.
module lcd_cmd_sched #(
    parameter int COMM_WIDTH  = 3,
    parameter int QUEUE_DEPTH = 4,
    parameter int QUEUE_AW    = 2,
    parameter int MAX_RETRY   = 2,
    parameter int ACK_TIMEOUT = 8,
    parameter int BOOT_CLEAR  = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  host_valid,
    input  logic [COMM_WIDTH-1:0] host_cmd,
    output logic                  host_ready,
    output logic                  host_reject,
    input  logic                  img_req,
    output logic                  img_done,
    output logic                  img_fail,
    output logic [COMM_WIDTH-1:0] ctrl_command,
    output logic                  ctrl_valid,
    input  logic                  ctrl_busy,
    input  logic                  ctrl_error,
    output logic                  init_done,
    output logic                  fault,
    output logic [COMM_WIDTH-1:0] fault_cmd,
    input  logic                  fault_clr,
    output logic                  sched_busy
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [COMM_WIDTH-1:0] CMD_INIT = COMM_WIDTH'(1);
    localparam logic [COMM_WIDTH-1:0] CMD_SHOW = COMM_WIDTH'(5);
    localparam logic [COMM_WIDTH-1:0] CMD_BCLR = COMM_WIDTH'(BOOT_CLEAR);
    localparam bit                    HAS_CLEAR = (BOOT_CLEAR != 0);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RESULT} state_t;
    typedef enum logic [1:0] {SRC_HOST, SRC_IMG, SRC_BOOT} src_t;

    state_t                  state_q, state_d;
    src_t                    cur_src_q, cur_src_d, rr_last_q, rr_last_d;
    logic [COMM_WIDTH-1:0]   mem_q [QUEUE_DEPTH];
    logic [COMM_WIDTH-1:0]   mem_d [QUEUE_DEPTH];
    logic [QUEUE_AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COMM_WIDTH-1:0]   cur_cmd_q, cur_cmd_d, fault_cmd_q, fault_cmd_d;
    logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic retry_pend_q, retry_pend_d, boot_pend_q, boot_pend_d, boot_step_q, boot_step_d;
    logic fail_q, fail_d, init_done_q, init_done_d, fault_q, fault_d;
    logic reject_q, reject_d, img_done_q, img_done_d, img_fail_q, img_fail_d;

    logic                  q_empty, q_full, cmd_legal, push, host_elig, img_elig;
    logic                  cand_vld, cand_pop;
    logic [COMM_WIDTH-1:0] q_head, cand_cmd;
    src_t                  cand_src;

    assign q_empty   = (wr_ptr_q == rd_ptr_q);
    assign q_full    = (wr_ptr_q[QUEUE_AW] != rd_ptr_q[QUEUE_AW]) &&
                       (wr_ptr_q[QUEUE_AW-1:0] == rd_ptr_q[QUEUE_AW-1:0]);
    assign q_head    = mem_q[rd_ptr_q[QUEUE_AW-1:0]];
    assign cmd_legal = (host_cmd != '0) && (host_cmd <= CMD_SHOW);
    assign push      = host_valid && !q_full && cmd_legal;
    // Until the panel is initialised only INITIAL may leave the queue; anything else stalls it.
    assign host_elig = !q_empty && (init_done_q || q_head == CMD_INIT);
    assign img_elig  = img_req && init_done_q;

    always_comb begin
        cand_vld = 1'b0;
        cand_pop = 1'b0;
        cand_cmd = q_head;
        cand_src = SRC_HOST;
        if (retry_pend_q) begin
            cand_vld = 1'b1;
            cand_cmd = cur_cmd_q;
            cand_src = cur_src_q;
        end else if (boot_pend_q) begin
            cand_vld = 1'b1;
            cand_cmd = boot_step_q ? CMD_BCLR : CMD_INIT;
            cand_src = SRC_BOOT;
        end else if (host_elig && (!img_elig || rr_last_q != SRC_HOST)) begin
            cand_vld = 1'b1;
            cand_pop = 1'b1;
        end else if (img_elig) begin
            cand_vld = 1'b1;
            cand_cmd = CMD_SHOW;
            cand_src = SRC_IMG;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_cmd_d    = cur_cmd_q;
        cur_src_d    = cur_src_q;
        rr_last_d    = rr_last_q;
        retry_cnt_d  = retry_cnt_q;
        retry_pend_d = retry_pend_q;
        boot_pend_d  = boot_pend_q;
        boot_step_d  = boot_step_q;
        tmo_d        = tmo_q;
        fail_d       = fail_q;
        init_done_d  = init_done_q;
        fault_d      = fault_q;
        fault_cmd_d  = fault_cmd_q;
        img_done_d   = 1'b0;
        img_fail_d   = 1'b0;
        reject_d     = host_valid && !q_full && !cmd_legal;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q + {{QUEUE_AW{1'b0}}, push};
        if (push) mem_d[wr_ptr_q[QUEUE_AW-1:0]] = host_cmd;
        if (fault_clr) begin
            fault_d     = 1'b0;
            fault_cmd_d = '0;
        end
        case (state_q)
            S_IDLE: if (!ctrl_busy && cand_vld) begin
                cur_cmd_d    = cand_cmd;
                cur_src_d    = cand_src;
                retry_pend_d = 1'b0;
                rd_ptr_d     = rd_ptr_q + {{QUEUE_AW{1'b0}}, cand_pop};
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                fail_d  = 1'b0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ctrl_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (ctrl_busy && ctrl_error) fail_d = 1'b1;
                if (!ctrl_busy) state_d = S_RESULT;
            end
            S_RESULT: begin
                state_d = S_IDLE;
                if (!fail_q) begin
                    retry_cnt_d = '0;
                    rr_last_d   = cur_src_q;
                    if (cur_cmd_q == CMD_INIT) init_done_d = 1'b1;
                    if (cur_src_q == SRC_IMG) img_done_d = 1'b1;
                    if (cur_src_q == SRC_BOOT) begin
                        if (!boot_step_q && HAS_CLEAR) boot_step_d = 1'b1;
                        else                           boot_pend_d = 1'b0;
                    end
                end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
                    retry_cnt_d  = retry_cnt_q + 1'b1;
                    retry_pend_d = 1'b1;
                end else begin
                    // A fresh exhaustion overrides a simultaneous fault_clr.
                    fault_d     = 1'b1;
                    fault_cmd_d = cur_cmd_q;
                    retry_cnt_d = '0;
                    if (cur_src_q == SRC_IMG) img_fail_d = 1'b1;
                    if (cur_src_q == SRC_BOOT) boot_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cur_cmd_q    <= '0;
            cur_src_q    <= SRC_HOST;
            rr_last_q    <= SRC_IMG;
            retry_cnt_q  <= '0;
            retry_pend_q <= 1'b0;
            boot_pend_q  <= 1'b1;
            boot_step_q  <= 1'b0;
            tmo_q        <= '0;
            fail_q       <= 1'b0;
            init_done_q  <= 1'b0;
            fault_q      <= 1'b0;
            fault_cmd_q  <= '0;
            img_done_q   <= 1'b0;
            img_fail_q   <= 1'b0;
            reject_q     <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            cur_cmd_q    <= cur_cmd_d;
            cur_src_q    <= cur_src_d;
            rr_last_q    <= rr_last_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_pend_q <= retry_pend_d;
            boot_pend_q  <= boot_pend_d;
            boot_step_q  <= boot_step_d;
            tmo_q        <= tmo_d;
            fail_q       <= fail_d;
            init_done_q  <= init_done_d;
            fault_q      <= fault_d;
            fault_cmd_q  <= fault_cmd_d;
            img_done_q   <= img_done_d;
            img_fail_q   <= img_fail_d;
            reject_q     <= reject_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    assign host_ready   = !q_full;
    assign host_reject  = reject_q;
    assign img_done     = img_done_q;
    assign img_fail     = img_fail_q;
    assign ctrl_valid   = (state_q == S_ISSUE);
    assign ctrl_command = cur_cmd_q;
    assign init_done    = init_done_q;
    assign fault        = fault_q;
    assign fault_cmd    = fault_cmd_q;
    assign sched_busy   = (state_q != S_IDLE) || !q_empty || boot_pend_q || retry_pend_q;
endmodule
